// File: rtl/preamble_frame_gate_if.sv
// Stream, configuration and status bundle between the preamble detector side and preamble_frame_gate.
interface preamble_frame_gate_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 48
);
  logic                 enable;
  logic [LEN_WIDTH-1:0] frame_len;
  logic [LEN_WIDTH-1:0] holdoff_len;
  logic [WIDTH-1:0]     i_tdata;
  logic                 i_tlast;
  logic                 i_tvalid;
  logic                 i_tready;
  logic [WIDTH-1:0]     o_tdata;
  logic                 o_tlast;
  logic                 o_tvalid;
  logic                 o_tready;
  logic [CNT_WIDTH-1:0] frame_count;
  logic [CNT_WIDTH-1:0] drop_count;

  modport master (
    output enable, frame_len, holdoff_len, i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid, frame_count, drop_count
  );

  modport slave (
    input  enable, frame_len, holdoff_len, i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid, frame_count, drop_count
  );
endinterface

// File: rtl/preamble_frame_gate.sv
// Gates the detector stream into one frame per accepted preamble mark, followed by a holdoff.
// Optional macro PREAMBLE_FRAME_GATE_RETRIGGER_EN: a mark during holdoff restarts capture.
module preamble_frame_gate #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 48
) (
  input logic                clk,
  input logic                reset,
  preamble_frame_gate_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLDOFF} state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0] hcnt_q, hcnt_d;
  logic                 first_q, first_d;
  logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

  logic                 arm_c;
  logic [LEN_WIDTH-1:0] len_c;
  logic                 i_tready_c, o_tvalid_c, o_tlast_c;
  logic [WIDTH-1:0]     o_tdata_c;

  assign arm_c     = bus.i_tvalid & bus.i_tlast & bus.enable;
  assign len_c     = (bus.frame_len == '0) ? LEN_WIDTH'(1) : bus.frame_len;
  assign o_tdata_c = bus.i_tdata;

  // Next-state, counters and stream handshake
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    hcnt_d        = hcnt_q;
    first_d       = first_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    i_tready_c    = 1'b1;
    o_tvalid_c    = 1'b0;
    o_tlast_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Hold the mark beat so it becomes the first forwarded sample
        if (arm_c) begin
          i_tready_c  = 1'b0;
          state_d     = S_CAPTURE;
          remaining_d = len_c;
          first_d     = 1'b1;
        end
      end

      S_CAPTURE: begin
        o_tvalid_c = bus.i_tvalid;
        i_tready_c = bus.o_tready;
        o_tlast_c  = (remaining_q == LEN_WIDTH'(1));
        if (bus.i_tvalid && bus.o_tready) begin
          first_d     = 1'b0;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (bus.i_tlast && !first_q) begin
            drop_count_d = drop_count_q + CNT_WIDTH'(1);
          end
          if (o_tlast_c) begin
            frame_count_d = frame_count_q + CNT_WIDTH'(1);
            if (bus.holdoff_len != '0) begin
              state_d = S_HOLDOFF;
              hcnt_d  = bus.holdoff_len;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      S_HOLDOFF: begin
`ifdef PREAMBLE_FRAME_GATE_RETRIGGER_EN
        if (arm_c) begin
          i_tready_c  = 1'b0;
          state_d     = S_CAPTURE;
          remaining_d = len_c;
          first_d     = 1'b1;
        end else
`endif
        if (bus.i_tvalid) begin
          hcnt_d = hcnt_q - LEN_WIDTH'(1);
          if (bus.i_tlast) begin
            drop_count_d = drop_count_q + CNT_WIDTH'(1);
          end
          if (hcnt_q == LEN_WIDTH'(1)) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      hcnt_q        <= '0;
      first_q       <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      hcnt_q        <= hcnt_d;
      first_q       <= first_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign bus.i_tready    = i_tready_c;
  assign bus.o_tvalid    = o_tvalid_c;
  assign bus.o_tlast     = o_tlast_c;
  assign bus.o_tdata     = o_tdata_c;
  assign bus.frame_count = frame_count_q;
  assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_preamble_frame_gate.sv
// Table-driven bench for preamble_frame_gate: ramp 0..30 with marks, checks forwarded beats and counters.
module tb_preamble_frame_gate;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned LEN_WIDTH = 16;
  localparam int unsigned CNT_WIDTH = 48;
  localparam int          NSAMP     = 31;

  logic clk;
  logic reset;

  preamble_frame_gate_if #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  preamble_frame_gate #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en;
    logic [15:0] fl;
    logic [15:0] fl_after;
    logic [15:0] ho;
    logic [31:0] marks;
    bit          toggle;
    logic [31:0] exp_fwd;
    logic [31:0] exp_last;
    int          exp_frames;
    int          exp_drops;
    int          exp_starts;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] got_d[$];
  logic        got_l[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.enable      = 1'b0;
    bus.frame_len   = '0;
    bus.holdoff_len = '0;
    bus.i_tdata     = '0;
    bus.i_tlast     = 1'b0;
    bus.i_tvalid    = 1'b0;
    bus.o_tready    = 1'b1;
    reset           = 1'b1;
    @(posedge clk);
    #1;
    check("reset o_tvalid", 64'(bus.o_tvalid), 64'd0);
    check("reset o_tlast", 64'(bus.o_tlast), 64'd0);
    check("reset i_tready", 64'(bus.i_tready), 64'd1);
    check("reset frame_count", 64'(bus.frame_count), 64'd0);
    check("reset drop_count", 64'(bus.drop_count), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drive the ramp through the DUT; abort_beats != 0 stops with that many beats taken
  task automatic run_vec(input vec_t v, input int abort_beats);
    int  idx;
    int  starts;
    int  mirror;
    bit  accept;
    int  j;
    do_reset();
    got_d.delete();
    got_l.delete();
    bus.enable      = v.en;
    bus.frame_len   = v.fl;
    bus.holdoff_len = v.ho;
    idx    = 0;
    starts = 0;
    mirror = 0;
    for (int cyc = 0; cyc < 400 && idx < NSAMP; cyc++) begin
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = 32'(idx);
      bus.i_tlast  = v.marks[idx];
      bus.o_tready = v.toggle ? (cyc % 2 == 0) : 1'b1;
      if (got_d.size() > 0) bus.frame_len = v.fl_after;
      if (abort_beats != 0 && got_d.size() == abort_beats) break;
      @(negedge clk);
      if (bus.o_tvalid && bus.o_tready) begin
        got_d.push_back(bus.o_tdata);
        got_l.push_back(bus.o_tlast);
      end
      if (bus.i_tvalid && !bus.i_tready && !bus.o_tvalid) starts++;
      if (bus.o_tvalid && (bus.i_tready != bus.o_tready)) mirror++;
      accept = bus.i_tvalid && bus.i_tready;
      @(posedge clk);
      #1;
      if (accept) idx++;
    end
    if (abort_beats != 0) return;
    check({v.name, " stream consumed"}, 64'(idx), 64'(NSAMP));
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({v.name, " beat count"}, 64'(got_d.size()), 64'($countones(v.exp_fwd)));
    j = 0;
    for (int k = 0; k < 32; k++) begin
      if (v.exp_fwd[k]) begin
        if (j < got_d.size()) begin
          check($sformatf("%s data[%0d]", v.name, j), 64'(got_d[j]), 64'(k));
          check($sformatf("%s last[%0d]", v.name, j), 64'(got_l[j]), 64'(v.exp_last[k]));
        end
        j++;
      end
    end
    check({v.name, " frame_count"}, 64'(bus.frame_count), 64'(v.exp_frames));
    check({v.name, " drop_count"}, 64'(bus.drop_count), 64'(v.exp_drops));
    check({v.name, " mark stalls"}, 64'(starts), 64'(v.exp_starts));
    check({v.name, " ready mirror"}, 64'(mirror), 64'd0);
  endtask

  vec_t vecs[8];
  vec_t vr;

  initial begin
    reset = 1'b1;
    //                  name        en  fl  fl_af ho  marks         tog  exp_fwd       exp_last      fr dr st
    vecs[0] = '{"capture",  1'b1, 16'd4, 16'd9, 16'd0, 32'h0000_0400, 1'b0, 32'h0000_3C00, 32'h0000_2000, 1, 0, 1};
    vecs[1] = '{"backpress",1'b1, 16'd8, 16'd8, 16'd0, 32'h0000_0400, 1'b1, 32'h0003_FC00, 32'h0002_0000, 1, 0, 1};
`ifdef PREAMBLE_FRAME_GATE_RETRIGGER_EN
    vecs[2] = '{"holdoff",  1'b1, 16'd2, 16'd2, 16'd5, 32'h0000_0211, 1'b0, 32'h0000_0633, 32'h0000_0422, 3, 0, 3};
    vecs[7] = '{"len1_ho3", 1'b1, 16'd1, 16'd1, 16'd3, 32'h0000_02A0, 1'b0, 32'h0000_02A0, 32'h0000_02A0, 3, 0, 3};
`else
    vecs[2] = '{"holdoff",  1'b1, 16'd2, 16'd2, 16'd5, 32'h0000_0211, 1'b0, 32'h0000_0603, 32'h0000_0402, 2, 1, 2};
    vecs[7] = '{"len1_ho3", 1'b1, 16'd1, 16'd1, 16'd3, 32'h0000_02A0, 1'b0, 32'h0000_0220, 32'h0000_0220, 2, 1, 2};
`endif
    vecs[3] = '{"len0",     1'b1, 16'd0, 16'd0, 16'd0, 32'h0000_0020, 1'b0, 32'h0000_0020, 32'h0000_0020, 1, 0, 1};
    vecs[4] = '{"mid_mark", 1'b1, 16'd4, 16'd4, 16'd0, 32'h0000_1400, 1'b0, 32'h0000_3C00, 32'h0000_2000, 1, 1, 1};
    vecs[5] = '{"disabled", 1'b0, 16'd4, 16'd4, 16'd0, 32'h0000_0400, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0};
    vecs[6] = '{"last_mark",1'b1, 16'd4, 16'd4, 16'd0, 32'h0000_2400, 1'b0, 32'h0000_3C00, 32'h0000_2000, 1, 1, 1};

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 0);

    // Async reset three beats into a six-beat frame
    vr = '{"abort", 1'b1, 16'd6, 16'd6, 16'd0, 32'h0000_0004, 1'b0, 32'h0000_00FC, 32'h0000_0080, 1, 0, 1};
    run_vec(vr, 3);
    check("abort beats taken", 64'(got_d.size()), 64'd3);
    check("abort no tlast", 64'((got_l.size() > 0 && got_l[0]) || (got_l.size() > 1 && got_l[1]) ||
                                (got_l.size() > 2 && got_l[2])), 64'd0);
    check("abort o_tvalid before reset", 64'(bus.o_tvalid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort o_tvalid in reset", 64'(bus.o_tvalid), 64'd0);
    check("abort o_tlast in reset", 64'(bus.o_tlast), 64'd0);
    check("abort frame_count in reset", 64'(bus.frame_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    vr = '{"fresh", 1'b1, 16'd6, 16'd6, 16'd0, 32'h0000_0020, 1'b0, 32'h0000_07E0, 32'h0000_0400, 1, 0, 1};
    run_vec(vr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
